// File: rtl/event_blinker.sv
// event_blinker
//   Turns one-cycle event strobes into fixed-length LED blinks. Strobes that
//   arrive while a blink (or its trailing dark gap) is in progress are counted
//   in a saturating queue and replayed back-to-back, each followed by a full
//   dark gap.
//
//   Parameters
//     ON_CYCLES   LED-on duration in clk cycles (>= 1)
//     GAP_CYCLES  dark gap after each blink in clk cycles (>= 1)
//     MAX_PEND    maximum queued events (>= 1), saturating
//
//   Ports
//     clk        system clock
//     reset_n    asynchronous active-low reset
//     pulse      event strobe, each high cycle is one event
//     led        blink output, high for ON_CYCLES per event
//     busy       high whenever a blink or gap is in progress
//     pending    number of queued events
//     overflow   sticky dropped-event flag   (EVENT_BLINKER_OVERFLOW_EN only)
//     clear_ovf  synchronous overflow clear  (EVENT_BLINKER_OVERFLOW_EN only)
//
//   Build option: define EVENT_BLINKER_OVERFLOW_EN to add overflow/clear_ovf.
//   Without it, dropped events are silently discarded.
module event_blinker #(
  parameter int unsigned ON_CYCLES  = 12_500_000,
  parameter int unsigned GAP_CYCLES = 12_500_000,
  parameter int unsigned MAX_PEND   = 7,
  localparam int unsigned PW   = $clog2(MAX_PEND + 1),
  localparam int unsigned TMAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES,
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pulse,
`ifdef EVENT_BLINKER_OVERFLOW_EN
  input  logic          clear_ovf,
  output logic          overflow,
`endif
  output logic          led,
  output logic          busy,
  output logic [PW-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP
  } state_t;

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);

  state_t        state;
  logic [TW-1:0] timer;

`ifdef EVENT_BLINKER_OVERFLOW_EN
  // A strobe is lost only when it would be queued while the queue is full.
  // On the last gap cycle a queued event is consumed at the same time, so a
  // strobe there never overflows.
  logic dropped;

  always_comb begin
    dropped = 1'b0;
    if (pulse && (pending == PEND_MAX)) begin
      if (state == ON)
        dropped = 1'b1;
      else if ((state == GAP) && (timer != '0))
        dropped = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      timer   <= '0;
      led     <= 1'b0;
      busy    <= 1'b0;
      pending <= '0;
`ifdef EVENT_BLINKER_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pulse) begin
            state <= ON;
            timer <= ON_LOAD;
            led   <= 1'b1;
            busy  <= 1'b1;
          end
        end

        ON: begin
          if (timer == '0) begin
            state <= GAP;
            timer <= GAP_LOAD;
            led   <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
          if (pulse && (pending != PEND_MAX))
            pending <= pending + PW'(1);
        end

        GAP: begin
          if (timer == '0) begin
            if (pending != '0) begin
              // Consume one queued event; a coincident strobe replaces it.
              state <= ON;
              timer <= ON_LOAD;
              led   <= 1'b1;
              if (!pulse)
                pending <= pending - PW'(1);
            end else if (pulse) begin
              // Fresh strobe on the last gap cycle restarts without idling.
              state <= ON;
              timer <= ON_LOAD;
              led   <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer - TW'(1);
            if (pulse && (pending != PEND_MAX))
              pending <= pending + PW'(1);
          end
        end

        default: begin
          state <= IDLE;
          timer <= '0;
          led   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase

`ifdef EVENT_BLINKER_OVERFLOW_EN
      if (dropped)
        overflow <= 1'b1;
      else if (clear_ovf)
        overflow <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_event_blinker.sv
// Testbench for event_blinker (ON_CYCLES=3, GAP_CYCLES=2, MAX_PEND=2).
// Works with or without EVENT_BLINKER_OVERFLOW_EN defined.
module tb_event_blinker;

  localparam int ONC  = 3;
  localparam int GAPC = 2;
  localparam int MAXP = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pulse = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       led;
  logic       busy;
  logic [1:0] pending;
`ifdef EVENT_BLINKER_OVERFLOW_EN
  logic       overflow;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  event_blinker #(
    .ON_CYCLES (ONC),
    .GAP_CYCLES(GAPC),
    .MAX_PEND  (MAXP)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pulse    (pulse),
`ifdef EVENT_BLINKER_OVERFLOW_EN
    .clear_ovf(clear_ovf),
    .overflow (overflow),
`endif
    .led      (led),
    .busy     (busy),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a blink started at edge s is lit after edges s..s+ON-1,
  // and its gap ends at edge s+ON+GAP, where the next queued/new event may start.
  bit m_active = 1'b0;
  int m_start  = 0;
  int m_pend   = 0;
  bit m_ovf    = 1'b0;
  int m_k      = 0;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_active = 1'b0;
        m_pend   = 0;
        m_ovf    = 1'b0;
      end else begin
        bit drop;
        drop = 1'b0;
        m_k++;
        if (m_active && (m_k == m_start + ONC + GAPC)) begin
          if (m_pend > 0) begin
            m_start = m_k;
            m_pend  = m_pend - 1 + int'(pulse);
          end else if (pulse) begin
            m_start = m_k;
          end else begin
            m_active = 1'b0;
          end
        end else if (m_active) begin
          if (pulse) begin
            if (m_pend < MAXP) m_pend++;
            else drop = 1'b1;
          end
        end else if (pulse) begin
          m_active = 1'b1;
          m_start  = m_k;
        end
        if (drop) m_ovf = 1'b1;
        else if (clear_ovf) m_ovf = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_led;
      exp_led = m_active && ((m_k - m_start) < ONC);
      check("model_led", 32'(led), 32'(exp_led));
      check("model_busy", 32'(busy), 32'(m_active));
      check("model_pending", 32'(pending), 32'(m_pend));
`ifdef EVENT_BLINKER_OVERFLOW_EN
      check("model_overflow", 32'(overflow), 32'(m_ovf));
`endif
    end
  end

  // Apply inputs for the next edge, then settle 1 time unit after it.
  task automatic step(input logic p, input logic c);
    pulse     = p;
    clear_ovf = c;
    @(posedge clk);
    #1;
    pulse     = 1'b0;
    clear_ovf = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    int lit;

    // Reset state
    #12;
    check("rst_led", 32'(led), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
`ifdef EVENT_BLINKER_OVERFLOW_EN
    check("rst_overflow", 32'(overflow), 32'd0);
`endif
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // 1. Single pulse
    step(1'b1, 1'b0);                                   // edge 0
    check("s1_led_c1", 32'(led), 32'd1);
    check("s1_busy_c1", 32'(busy), 32'd1);
    idle_steps(2);                                      // edges 1,2
    check("s1_led_c3", 32'(led), 32'd1);
    step(1'b0, 1'b0);                                   // edge 3
    check("s1_led_c4", 32'(led), 32'd0);
    check("s1_busy_c4", 32'(busy), 32'd1);
    step(1'b0, 1'b0);                                   // edge 4
    check("s1_busy_c5", 32'(busy), 32'd1);
    step(1'b0, 1'b0);                                   // edge 5
    check("s1_busy_c6", 32'(busy), 32'd0);
    check("s1_pending", 32'(pending), 32'd0);
    idle_steps(3);

    // 2. Pulses at edges 0 and 2
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);                                   // edge 2
    check("s2_pending_c3", 32'(pending), 32'd1);
    idle_steps(2);                                      // edges 3,4
    check("s2_led_c5", 32'(led), 32'd0);
    step(1'b0, 1'b0);                                   // edge 5
    check("s2_led_c6", 32'(led), 32'd1);
    check("s2_pending_c6", 32'(pending), 32'd0);
    idle_steps(4);                                      // edges 6..9
    check("s2_busy_c10", 32'(busy), 32'd1);
    step(1'b0, 1'b0);                                   // edge 10
    check("s2_busy_c11", 32'(busy), 32'd0);
    idle_steps(3);

    // 3. pulse held for edges 0-4: saturation and overflow
    lit = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      if (led) lit++;
      if (i == 2) check("s3_pending_sat", 32'(pending), 32'd2);
`ifdef EVENT_BLINKER_OVERFLOW_EN
      if (i == 2) check("s3_ovf_c3", 32'(overflow), 32'd0);
      if (i == 3) check("s3_ovf_c4", 32'(overflow), 32'd1);
`endif
    end
    check("s3_pending_hold", 32'(pending), 32'd2);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0);
      if (led) lit++;
    end
    check("s3_lit_cycles", 32'(lit), 32'(3 * ONC));
    check("s3_idle", 32'(busy), 32'd0);
`ifdef EVENT_BLINKER_OVERFLOW_EN
    check("s3_ovf_sticky", 32'(overflow), 32'd1);
    step(1'b0, 1'b1);
    check("s3_ovf_clear", 32'(overflow), 32'd0);
`endif
    idle_steps(2);

    // 4. Pulse on the last gap cycle restarts without an IDLE cycle
    step(1'b1, 1'b0);                                   // edge 0
    idle_steps(2);                                      // edges 1,2
    step(1'b0, 1'b0);                                   // edge 3
    check("s4_led_c4", 32'(led), 32'd0);
    step(1'b0, 1'b0);                                   // edge 4
    check("s4_led_c5", 32'(led), 32'd0);
    step(1'b1, 1'b0);                                   // edge 5
    check("s4_led_c6", 32'(led), 32'd1);
    check("s4_busy_c6", 32'(busy), 32'd1);
    check("s4_pending_c6", 32'(pending), 32'd0);
    idle_steps(12);
    check("s4_idle", 32'(busy), 32'd0);

    // 5. Asynchronous reset mid-blink with two events queued
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("s5_pending_pre", 32'(pending), 32'd2);
    check("s5_led_pre", 32'(led), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("s5_led_rst", 32'(led), 32'd0);
    check("s5_busy_rst", 32'(busy), 32'd0);
    check("s5_pending_rst", 32'(pending), 32'd0);
`ifdef EVENT_BLINKER_OVERFLOW_EN
    check("s5_ovf_rst", 32'(overflow), 32'd0);
`endif
    #4 reset_n = 1'b1;
    @(posedge clk);
    #1;
    lit = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0);
      if (led || busy) lit++;
    end
    check("s5_no_blinks", 32'(lit), 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
